// File: rtl/si_cmd_master.sv
// si_cmd_master: initiator on the si_* bus. Collects {addr,data} frames from the host byte
// stream (MSB byte first per field), presents each as a request and holds it until si_ack.
// A request is dropped with a one-cycle timeout_err pulse if it goes unacknowledged too long.
module si_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  rx_ack,
    input  logic                  frame_clr,
    output logic [ADDR_WIDTH-1:0] si_addr,
    output logic [DATA_WIDTH-1:0] si_data,
    output logic                  si_rdy,
    input  logic                  si_ack,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam logic [7:0]  AddrLast   = 8'(ADDR_BYTES - 1);
    localparam logic [7:0]  DataLast   = 8'(DATA_BYTES - 1);
    // Last ISSUE count before a drop; unused when the timeout is disabled.
    localparam logic [15:0] TmoLast    = (TIMEOUT_CYCLES == 0) ? 16'd0
                                                               : 16'(TIMEOUT_CYCLES - 1);
    localparam bit          TmoEnable  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {StAddr, StData, StIssue} state_e;

    state_e                state_q, state_d;
    logic [7:0]            byte_cnt_q, byte_cnt_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  terr_q, terr_d;

    // Next-state: byte assembly, request hold, ack/timeout handling.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        terr_d     = 1'b0;
        rx_ack     = rst & rx_rdy & (state_q != StIssue);

        unique case (state_q)
            StAddr: begin
                if (frame_clr) begin
                    // Byte (if any) is still consumed, just not stored.
                    byte_cnt_d = 8'd0;
                    state_d    = StAddr;
                end else if (rx_ack) begin
                    addr_d = (addr_q << 8) | ADDR_WIDTH'(rx_data);
                    if (byte_cnt_q == AddrLast) begin
                        byte_cnt_d = 8'd0;
                        state_d    = StData;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            StData: begin
                if (frame_clr) begin
                    byte_cnt_d = 8'd0;
                    state_d    = StAddr;
                end else if (rx_ack) begin
                    data_d = (data_q << 8) | DATA_WIDTH'(rx_data);
                    if (byte_cnt_q == DataLast) begin
                        byte_cnt_d = 8'd0;
                        tmo_cnt_d  = 16'd0;
                        state_d    = StIssue;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            StIssue: begin
                // Ack takes priority over a timeout on the same edge.
                if (si_ack) begin
                    state_d = StAddr;
                end else if (TmoEnable && (tmo_cnt_q == TmoLast)) begin
                    state_d = StAddr;
                    terr_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = StAddr;
                byte_cnt_d = 8'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StAddr;
            byte_cnt_q <= 8'd0;
            tmo_cnt_q  <= 16'd0;
            addr_q     <= '0;
            data_q     <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            terr_q     <= terr_d;
        end
    end

    // Outputs derived from registered state only.
    always_comb begin
        si_addr     = addr_q;
        si_data     = data_q;
        si_rdy      = (state_q == StIssue);
        busy        = (state_q == StIssue) | (byte_cnt_q != 8'd0) | (state_q == StData);
        timeout_err = terr_q;
    end

endmodule
